ftsd_scan_ctrl: RTL and testbench

- Sequencer for the shared 4-digit 14-segment display.
- Time-multiplexes one digit at a time and inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value behind a load/ack handshake, so updates land only on frame boundaries.
- Optional leading-zero suppression.
- Sits between the datapath producing digit values and the segment decoder, replacing the free-running divider tap as the scan source.

---
 rtl/ftsd_scan_ctrl_if.sv | 32 +++
 rtl/ftsd_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ftsd_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ftsd_scan_ctrl_if.sv
// ftsd_scan_ctrl_if: groups the producer-side controls and the display-side outputs of the
// 4-digit 14-segment scan sequencer.
//   enable     : 1 = scan running, 0 = display dark
//   lz_blank   : 1 = suppress leading zeros
//   digit_in   : new value, [15:12] = digit 0 (leftmost) ... [3:0] = digit 3 (rightmost)
//   load       : level request to capture digit_in (digit_in stable while high)
//   load_ack   : one-cycle pulse on the cycle after capture
//   scan_sel   : index of the digit currently addressed
//   ftsd_ctl   : active-low digit enables, digit k -> bit (3-k)
//   ftsd_in    : nibble for the segment decoder
//   frame_tick : one-cycle pulse in the last cycle of each 4-digit frame
interface ftsd_scan_ctrl_if;
   logic        enable;
   logic        lz_blank;
   logic [15:0] digit_in;
   logic        load;
   logic        load_ack;
   logic [1:0]  scan_sel;
   logic [3:0]  ftsd_ctl;
   logic [3:0]  ftsd_in;
   logic        frame_tick;

   modport master (
      output enable, lz_blank, digit_in, load,
      input  load_ack, scan_sel, ftsd_ctl, ftsd_in, frame_tick
   );

   modport slave (
      input  enable, lz_blank, digit_in, load,
      output load_ack, scan_sel, ftsd_ctl, ftsd_in, frame_tick
   );
endinterface

// File: rtl/ftsd_scan_ctrl.sv
// ftsd_scan_ctrl: time-multiplexed scan sequencer for a shared 4-digit 14-segment display.
// Each digit gets BLANK_CYC cycles with all digits off, then SHOW_CYC cycles driven. The
// displayed value sits in a shadow register that is only reloaded in IDLE or on the frame
// boundary, behind a load/ack handshake. Optional leading-zero suppression.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ftsd_scan_ctrl_if slave (controls in, display outputs out)
// All outputs are registered; they are computed from next-state so that each output
// register lines up with the state register it describes.
module ftsd_scan_ctrl #(
   parameter int unsigned      CNT_W     = 16,
   parameter logic [CNT_W-1:0] SHOW_CYC  = CNT_W'(40000),
   parameter logic [CNT_W-1:0] BLANK_CYC = CNT_W'(400)
) (
   input logic            clk,
   input logic            rst_n,
   ftsd_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

   state_e           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      shadow_q, shadow_d;

   logic             load_ack_q, load_ack_d;
   logic [1:0]       scan_sel_q, scan_sel_d;
   logic [3:0]       ftsd_ctl_q, ftsd_ctl_d;
   logic [3:0]       ftsd_in_q, ftsd_in_d;
   logic             frame_tick_q, frame_tick_d;

   logic             capture;
   logic [3:0]       nib_d;
   logic             supp_d;

   // frame_tick_q is high exactly in the last SHOW cycle of digit 3, i.e. the boundary edge.
   assign capture  = bus.load & ((state_q == StIdle) | frame_tick_q);
   assign shadow_d = capture ? bus.digit_in : shadow_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            idx_d = 2'd0;
            cnt_d = '0;
            if (bus.enable) begin
               state_d = (BLANK_CYC == '0) ? StShow : StBlank;
            end
         end
         StBlank: begin
            if (!bus.enable) begin
               state_d = StIdle;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end else if (cnt_q == BLANK_CYC - 1'b1) begin
               state_d = StShow;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StShow: begin
            if (!bus.enable) begin
               state_d = StIdle;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end else if (cnt_q == SHOW_CYC - 1'b1) begin
               state_d = (BLANK_CYC == '0) ? StShow : StBlank;
               idx_d   = idx_q + 2'd1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = 2'd0;
            cnt_d   = '0;
         end
      endcase
   end

   // Nibble and suppression for the digit that will be addressed next cycle.
   always_comb begin
      nib_d  = 4'h0;
      supp_d = 1'b0;
      unique case (idx_d)
         2'd0: begin
            nib_d  = shadow_d[15:12];
            supp_d = (shadow_d[15:12] == 4'h0);
         end
         2'd1: begin
            nib_d  = shadow_d[11:8];
            supp_d = (shadow_d[15:8] == 8'h00);
         end
         2'd2: begin
            nib_d  = shadow_d[7:4];
            supp_d = (shadow_d[15:4] == 12'h000);
         end
         2'd3: begin
            nib_d  = shadow_d[3:0];
            supp_d = 1'b0;
         end
         default: begin
            nib_d  = 4'h0;
            supp_d = 1'b0;
         end
      endcase
      supp_d = supp_d & bus.lz_blank;
   end

   always_comb begin
      ftsd_ctl_d   = 4'hF;
      ftsd_in_d    = 4'h0;
      scan_sel_d   = 2'd0;
      load_ack_d   = capture;
      frame_tick_d = (state_d == StShow) && (idx_d == 2'd3) && (cnt_d == SHOW_CYC - 1'b1);
      if (state_d != StIdle) begin
         ftsd_in_d  = nib_d;
         scan_sel_d = idx_d;
      end
      if ((state_d == StShow) && !supp_d) begin
         ftsd_ctl_d = ~(4'b1000 >> idx_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         idx_q        <= 2'd0;
         cnt_q        <= '0;
         shadow_q     <= 16'h0000;
         load_ack_q   <= 1'b0;
         scan_sel_q   <= 2'd0;
         ftsd_ctl_q   <= 4'hF;
         ftsd_in_q    <= 4'h0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         load_ack_q   <= load_ack_d;
         scan_sel_q   <= scan_sel_d;
         ftsd_ctl_q   <= ftsd_ctl_d;
         ftsd_in_q    <= ftsd_in_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.load_ack   = load_ack_q;
   assign bus.scan_sel   = scan_sel_q;
   assign bus.ftsd_ctl   = ftsd_ctl_q;
   assign bus.ftsd_in    = ftsd_in_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// tb_ftsd_scan_ctrl: drives two scan controllers (SHOW=4/BLANK=2 and SHOW=1/BLANK=0) with
// directed-then-random stimulus and compares every output, every cycle, against a model that
// derives the display position from the time elapsed since the scan started.
module tb_ftsd_scan_ctrl;

   logic clk;
   logic rst_n;

   ftsd_scan_ctrl_if if_a ();
   ftsd_scan_ctrl_if if_b ();

   ftsd_scan_ctrl #(
      .CNT_W     (16),
      .SHOW_CYC  (16'd4),
      .BLANK_CYC (16'd2)
   ) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   ftsd_scan_ctrl #(
      .CNT_W     (16),
      .SHOW_CYC  (16'd1),
      .BLANK_CYC (16'd0)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int s_cyc[2] = '{4, 1};
   int b_cyc[2] = '{2, 0};

   // Stimulus
   logic        en;
   logic        lz;
   logic        ld  [2];
   logic [15:0] din [2];

   // Reference model state and expected outputs
   bit          m_run [2];
   int          m_t   [2];
   logic [15:0] m_sh  [2];
   logic [3:0]  e_ctl [2];
   logic [3:0]  e_in  [2];
   logic [1:0]  e_sel [2];
   logic        e_ack [2];
   logic        e_tick[2];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h, want %0h", tag, cyc, act, exp);
      end
   endtask

   function automatic void model_reset(int k);
      m_run[k]  = 1'b0;
      m_t[k]    = 0;
      m_sh[k]   = 16'h0000;
      e_ctl[k]  = 4'hF;
      e_in[k]   = 4'h0;
      e_sel[k]  = 2'd0;
      e_ack[k]  = 1'b0;
      e_tick[k] = 1'b0;
   endfunction

   // One clock edge of the model, from the inputs held across that edge.
   function automatic void model_step(int k);
      int         per;
      int         frm;
      int         p;
      int         d;
      int         w;
      logic       boundary;
      logic       capture;
      logic       supp;
      logic [15:0] upper;
      logic [3:0] one;
      if (!rst_n) begin
         model_reset(k);
         return;
      end
      per      = s_cyc[k] + b_cyc[k];
      frm      = 4 * per;
      boundary = m_run[k] && ((m_t[k] % frm) == frm - 1);
      capture  = ld[k] && (!m_run[k] || boundary);
      if (capture) m_sh[k] = din[k];
      e_ack[k] = capture;
      if (!m_run[k]) begin
         m_run[k] = en;
         m_t[k]   = 0;
      end else if (!en) begin
         m_run[k] = 1'b0;
      end else begin
         m_t[k]++;
      end
      if (m_run[k]) begin
         p     = m_t[k] % frm;
         d     = p / per;
         w     = p % per;
         upper = m_sh[k] >> (4 * (3 - d));
         supp  = lz && (d < 3) && (upper == 16'h0000);
         one   = 4'b1000 >> d;
         e_ctl[k]  = ((w < b_cyc[k]) || supp) ? 4'hF : ~one;
         e_in[k]   = upper[3:0];
         e_sel[k]  = 2'(d);
         e_tick[k] = (p == frm - 1);
      end else begin
         e_ctl[k]  = 4'hF;
         e_in[k]   = 4'h0;
         e_sel[k]  = 2'd0;
         e_tick[k] = 1'b0;
      end
   endfunction

   task automatic apply_inputs();
      if_a.enable   = en;
      if_a.lz_blank = lz;
      if_a.load     = ld[0];
      if_a.digit_in = din[0];
      if_b.enable   = en;
      if_b.lz_blank = lz;
      if_b.load     = ld[1];
      if_b.digit_in = din[1];
   endtask

   task automatic check_outputs(int k, logic [3:0] ctl, logic [3:0] nib, logic [1:0] sel,
                                logic ack, logic tick);
      string nm;
      nm = (k == 0) ? "a" : "b";
      check_eq({nm, " ftsd_ctl"}, 32'(ctl), 32'(e_ctl[k]));
      check_eq({nm, " ftsd_in"}, 32'(nib), 32'(e_in[k]));
      check_eq({nm, " scan_sel"}, 32'(sel), 32'(e_sel[k]));
      check_eq({nm, " load_ack"}, 32'(ack), 32'(e_ack[k]));
      check_eq({nm, " frame_tick"}, 32'(tick), 32'(e_tick[k]));
   endtask

   // One clock: step the model, check both DUTs, then let the masters drop load on ack.
   task automatic tick_cycle(bit rnd_drop);
      logic ack[2];
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
      #1;
      check_outputs(0, if_a.ftsd_ctl, if_a.ftsd_in, if_a.scan_sel, if_a.load_ack,
                    if_a.frame_tick);
      check_outputs(1, if_b.ftsd_ctl, if_b.ftsd_in, if_b.scan_sel, if_b.load_ack,
                    if_b.frame_tick);
      ack[0] = if_a.load_ack;
      ack[1] = if_b.load_ack;
      for (int k = 0; k < 2; k++) begin
         if (ld[k] && ack[k] && (!rnd_drop || $urandom_range(0, 3) != 0)) ld[k] = 1'b0;
      end
      apply_inputs();
   endtask

   task automatic run_cycles(int n);
      for (int i = 0; i < n; i++) tick_cycle(1'b0);
   endtask

   task automatic wait_ctl_a(logic [3:0] v, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick_cycle(1'b0);
         if (if_a.ftsd_ctl == v) begin
            found = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(found), 32'd1);
   endtask

   task automatic load_both(logic [15:0] v);
      ld[0]  = 1'b1;
      ld[1]  = 1'b1;
      din[0] = v;
      din[1] = v;
      apply_inputs();
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      lz     = 1'b0;
      ld[0]  = 1'b0;
      ld[1]  = 1'b0;
      din[0] = 16'h0000;
      din[1] = 16'h0000;
      model_reset(0);
      model_reset(1);
      apply_inputs();
      run_cycles(3);
      rst_n = 1'b1;
      run_cycles(2);

      // Load in IDLE, then scan two frames.
      load_both(16'h1234);
      run_cycles(2);
      en = 1'b1;
      apply_inputs();
      run_cycles(50);

      // Load requested during digit 1 SHOW lands on the frame boundary.
      wait_ctl_a(4'b1011, "wait digit1 show");
      load_both(16'h5678);
      run_cycles(60);

      // Leading-zero suppression.
      lz = 1'b1;
      load_both(16'h0040);
      run_cycles(60);
      load_both(16'h0000);
      run_cycles(60);
      lz = 1'b0;
      apply_inputs();

      // enable drop during digit 2 SHOW, then restart.
      load_both(16'h9ABC);
      run_cycles(30);
      wait_ctl_a(4'b1101, "wait digit2 show en");
      en = 1'b0;
      apply_inputs();
      run_cycles(4);
      en = 1'b1;
      apply_inputs();
      run_cycles(40);

      // Asynchronous reset mid-SHOW of digit 2.
      wait_ctl_a(4'b1101, "wait digit2 show rst");
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst ftsd_ctl", 32'(if_a.ftsd_ctl), 32'hF);
      check_eq("rst scan_sel", 32'(if_a.scan_sel), 32'h0);
      check_eq("rst load_ack", 32'(if_a.load_ack), 32'h0);
      check_eq("rst ftsd_in", 32'(if_a.ftsd_in), 32'h0);
      check_eq("rst frame_tick", 32'(if_a.frame_tick), 32'h0);
      model_reset(0);
      model_reset(1);
      ld[0] = 1'b0;
      ld[1] = 1'b0;
      apply_inputs();
      run_cycles(2);
      rst_n = 1'b1;
      run_cycles(60);

      // Random phase.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 29) == 0) lz = ~lz;
         for (int k = 0; k < 2; k++) begin
            if (!ld[k] && $urandom_range(0, 15) == 0) begin
               ld[k]  = 1'b1;
               din[k] = rand_digits();
            end
         end
         apply_inputs();
         tick_cycle(1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
